boot_loader: RTL and testbench



---
 rtl/boot_loader_pkg.sv | 45 ++++
 rtl/boot_loader.sv | 194 +++++++++++++++++++
 tb/tb_boot_loader.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
`default_nettype none
//============================================================================
// Module      : boot_loader_pkg
// Description : Shared definitions for the boot loader. Holds the loader
//               state encoding, the bit layout of the stream header word
//               and the header target codes.
//               Header word: [31] target, [30:16] base word index,
//               [15:0] word count N (N == 0 terminates the load).
// Revision    : 1.0 - initial release
//============================================================================

// Memory word widths shared with the CPU tops.
`ifndef WORD
`define WORD 64
`endif
`ifndef INST_SIZE
`define INST_SIZE 32
`endif

package boot_loader_pkg;

    // Loader states, explicitly 3 bits wide with fixed codes.
    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_INST    = 3'd1,
        ST_DATA_LO = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    // Header field positions.
    localparam int HDR_TGT_BIT  = 31;
    localparam int HDR_BASE_MSB = 30;
    localparam int HDR_BASE_LSB = 16;
    localparam int HDR_CNT_MSB  = 15;
    localparam int HDR_CNT_LSB  = 0;

    // Header target codes.
    localparam logic TGT_INST = 1'b0;
    localparam logic TGT_DATA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
//============================================================================
// Module      : boot_loader
// Description : Fills instruction and data memory from a 32-bit word stream
//               and holds the CPU in reset until a terminating header
//               (count 0) arrives. A header whose block would run past the
//               end of its target memory parks the loader in a sticky error
//               state that drains the stream and never releases the CPU.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_valid/in_ready - stream handshake, in_data 32-bit beat
//               imem_we/addr/wdata - instruction memory write port
//               dmem_we/addr/wdata - data memory write port (64-bit words,
//                                    sent low half first)
//               cpu_rst_n         - active-low reset to the CPU top
//               done / err        - load complete / header range error
// Revision    : 1.0 - initial release
//============================================================================
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int IMEM_SIZE = 1024,
    parameter int DMEM_SIZE = 1024,
    parameter int IA_W      = $clog2(IMEM_SIZE),
    parameter int DA_W      = $clog2(DMEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [IA_W-1:0]       imem_addr,
    output logic [`INST_SIZE-1:0] imem_wdata,
    output logic                  dmem_we,
    output logic [DA_W-1:0]       dmem_addr,
    output logic [`WORD-1:0]      dmem_wdata,
    output logic                  cpu_rst_n,
    output logic                  done,
    output logic                  err
);

    // One index register serves both memories, so it is as wide as the
    // larger of the two address spaces.
    localparam int          IX_W       = (IA_W > DA_W) ? IA_W : DA_W;
    localparam logic [16:0] C_IMEM_LIM = 17'(IMEM_SIZE);
    localparam logic [16:0] C_DMEM_LIM = 17'(DMEM_SIZE);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_ready;
    logic [IX_W-1:0]         r_idx;
    logic [IX_W-1:0]         w_idx_nxt;
    logic [15:0]             r_rem;
    logic [15:0]             w_rem_nxt;
    logic [31:0]             r_low;
    logic [31:0]             w_low_nxt;
    logic                    w_imem_wr;
    logic                    w_dmem_wr;
    logic                    r_imem_we;
    logic [IA_W-1:0]         r_imem_addr;
    logic [`INST_SIZE-1:0]   r_imem_wdata;
    logic                    r_dmem_we;
    logic [DA_W-1:0]         r_dmem_addr;
    logic [`WORD-1:0]        r_dmem_wdata;

    logic                    w_accept;
    logic                    w_hdr_tgt;
    logic [14:0]             w_hdr_base;
    logic [15:0]             w_hdr_cnt;
    logic [16:0]             w_hdr_end;
    logic [16:0]             w_hdr_lim;

    assign w_accept   = in_valid & r_ready;
    assign w_hdr_tgt  = in_data[HDR_TGT_BIT];
    assign w_hdr_base = in_data[HDR_BASE_MSB:HDR_BASE_LSB];
    assign w_hdr_cnt  = in_data[HDR_CNT_MSB:HDR_CNT_LSB];
    // 17-bit sum so a block running off the end can never wrap back in range.
    assign w_hdr_end  = 17'(w_hdr_base) + 17'(w_hdr_cnt);
    assign w_hdr_lim  = (w_hdr_tgt == TGT_DATA) ? C_DMEM_LIM : C_IMEM_LIM;

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rem_nxt   = r_rem;
        w_low_nxt   = r_low;
        w_imem_wr   = 1'b0;
        w_dmem_wr   = 1'b0;
        case (r_state)
            ST_HDR: begin
                if (w_accept) begin
                    if (w_hdr_cnt == 16'd0) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_hdr_end > w_hdr_lim) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_idx_nxt   = IX_W'(w_hdr_base);
                        w_rem_nxt   = w_hdr_cnt;
                        w_state_nxt = (w_hdr_tgt == TGT_DATA) ? ST_DATA_LO : ST_INST;
                    end
                end
            end
            ST_INST: begin
                if (w_accept) begin
                    w_imem_wr = 1'b1;
                    w_idx_nxt = r_idx + 1'b1;
                    w_rem_nxt = r_rem - 16'd1;
                    if (r_rem == 16'd1) begin
                        w_state_nxt = ST_HDR;
                    end
                end
            end
            ST_DATA_LO: begin
                if (w_accept) begin
                    w_low_nxt   = in_data;
                    w_state_nxt = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (w_accept) begin
                    w_dmem_wr   = 1'b1;
                    w_idx_nxt   = r_idx + 1'b1;
                    w_rem_nxt   = r_rem - 16'd1;
                    w_state_nxt = (r_rem == 16'd1) ? ST_HDR : ST_DATA_LO;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_HDR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs. in_ready is registered so it reads 0
    // straight out of reset and drops on the same edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready      <= 1'b0;
            r_idx        <= '0;
            r_rem        <= '0;
            r_low        <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
        end else begin
            r_ready   <= (w_state_nxt != ST_DONE);
            r_idx     <= w_idx_nxt;
            r_rem     <= w_rem_nxt;
            r_low     <= w_low_nxt;
            r_imem_we <= w_imem_wr;
            r_dmem_we <= w_dmem_wr;
            // Address/data only move on a write so they hold between pulses.
            if (w_imem_wr) begin
                r_imem_addr  <= r_idx[IA_W-1:0];
                r_imem_wdata <= in_data;
            end
            if (w_dmem_wr) begin
                r_dmem_addr  <= r_idx[DA_W-1:0];
                r_dmem_wdata <= {in_data, r_low};
            end
        end
    end

    assign in_ready   = r_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign done       = (r_state == ST_DONE);
    assign cpu_rst_n  = (r_state == ST_DONE);
    assign err        = (r_state == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
//============================================================================
// Module      : tb_boot_loader
// Description : Directed self-checking bench for boot_loader. Each scenario
//               task drives stream beats and compares write-port and status
//               outputs against hand-computed values one cycle after accept.
// Revision    : 1.0 - initial release
//============================================================================
module tb_boot_loader;

    logic        tb_clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        dmem_we;
    logic [9:0]  dmem_addr;
    logic [63:0] dmem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int n_imem_we = 0;
    int n_dmem_we = 0;

    boot_loader dut (
        .clk        (tb_clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .err        (err)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    // Each write pulse spans exactly one falling edge.
    always @(negedge tb_clk) begin
        if (imem_we === 1'b1) n_imem_we++;
        if (dmem_we === 1'b1) n_dmem_we++;
    end

    // Present one beat, wait (bounded) for in_ready, return 1 time unit
    // after the accepting edge.
    task automatic beat(input logic [31:0] d);
        int waited;
        waited = 0;
        @(negedge tb_clk);
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge tb_clk);
            waited++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_ready_timeout data=%h in_ready=%b want 1", d, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge tb_clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic reset_dut();
        @(negedge tb_clk);
        rst = 1'b1;
        @(negedge tb_clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge tb_clk);
        rst = 1'b1;
        @(posedge tb_clk);
        #1;
        total++;
        if ({in_ready, imem_we, dmem_we, cpu_rst_n, done, err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {in_ready, imem_we, dmem_we, cpu_rst_n, done, err});
        end
        total++;
        if ({imem_addr, imem_wdata, dmem_addr, dmem_wdata} !== 116'd0) begin
            bad++;
            $display("FAIL reset_ports got ia=%h iw=%h da=%h dw=%h want 0",
                     imem_addr, imem_wdata, dmem_addr, dmem_wdata);
        end
        @(negedge tb_clk);
        rst = 1'b0;
        @(posedge tb_clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_after got %b want 1", in_ready);
        end
    endtask

    task automatic test_data_load();
        int i0, d0;
        i0 = n_imem_we;
        d0 = n_dmem_we;
        beat(32'h8003_0002);
        beat(32'h0000_1FF8);
        total++;
        if (dmem_we !== 1'b0) begin
            bad++;
            $display("FAIL data_half_we got %b want 0", dmem_we);
        end
        beat(32'h0000_0000);
        total++;
        if ({dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 10'd3, 64'h1FF8}) begin
            bad++;
            $display("FAIL data_word0 got we=%b a=%0d d=%h want we=1 a=3 d=1ff8",
                     dmem_we, dmem_addr, dmem_wdata);
        end
        beat(32'h0000_0064);
        total++;
        if ({dmem_we, dmem_addr, dmem_wdata} !== {1'b0, 10'd3, 64'h1FF8}) begin
            bad++;
            $display("FAIL data_hold got we=%b a=%0d d=%h want we=0 a=3 d=1ff8",
                     dmem_we, dmem_addr, dmem_wdata);
        end
        beat(32'h0000_0000);
        total++;
        if ({dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 10'd4, 64'h64}) begin
            bad++;
            $display("FAIL data_word1 got we=%b a=%0d d=%h want we=1 a=4 d=64",
                     dmem_we, dmem_addr, dmem_wdata);
        end
        @(negedge tb_clk);
        @(negedge tb_clk);
        total++;
        if ((n_dmem_we - d0) !== 2 || (n_imem_we - i0) !== 0) begin
            bad++;
            $display("FAIL data_pulses got d=%0d i=%0d want d=2 i=0",
                     n_dmem_we - d0, n_imem_we - i0);
        end
    endtask

    task automatic test_stall();
        int d0;
        d0 = n_dmem_we;
        beat(32'h8010_0001);
        beat(32'hDEAD_BEEF);
        repeat (2) begin
            @(posedge tb_clk);
            #1;
            total++;
            if (dmem_we !== 1'b0) begin
                bad++;
                $display("FAIL stall_we got %b want 0", dmem_we);
            end
        end
        beat(32'h1234_5678);
        total++;
        if ({dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 10'd16, 64'h1234_5678_DEAD_BEEF}) begin
            bad++;
            $display("FAIL stall_word got we=%b a=%0d d=%h want we=1 a=16 d=12345678deadbeef",
                     dmem_we, dmem_addr, dmem_wdata);
        end
        @(negedge tb_clk);
        @(negedge tb_clk);
        total++;
        if ((n_dmem_we - d0) !== 1) begin
            bad++;
            $display("FAIL stall_pulses got %0d want 1", n_dmem_we - d0);
        end
    endtask

    task automatic test_boundary();
        beat(32'h03FF_0001);
        beat(32'hCAFE_F00D);
        total++;
        if ({imem_we, imem_addr, imem_wdata, err} !== {1'b1, 10'd1023, 32'hCAFE_F00D, 1'b0}) begin
            bad++;
            $display("FAIL boundary got we=%b a=%0d d=%h err=%b want we=1 a=1023 d=cafef00d err=0",
                     imem_we, imem_addr, imem_wdata, err);
        end
    endtask

    task automatic test_inst_load();
        beat(32'h0000_0002);
        beat(32'h8B1F_03E0);
        total++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h8B1F_03E0}) begin
            bad++;
            $display("FAIL inst_word0 got we=%b a=%0d d=%h want we=1 a=0 d=8b1f03e0",
                     imem_we, imem_addr, imem_wdata);
        end
        beat(32'h1400_0000);
        total++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd1, 32'h1400_0000}) begin
            bad++;
            $display("FAIL inst_word1 got we=%b a=%0d d=%h want we=1 a=1 d=14000000",
                     imem_we, imem_addr, imem_wdata);
        end
        total++;
        if ({cpu_rst_n, done} !== 2'b00) begin
            bad++;
            $display("FAIL inst_pre_done got rst_n/done=%b want 00", {cpu_rst_n, done});
        end
        beat(32'h0000_0000);
        total++;
        if ({cpu_rst_n, done, in_ready, imem_we} !== 4'b1100) begin
            bad++;
            $display("FAIL inst_done got rst_n/done/rdy/we=%b want 1100",
                     {cpu_rst_n, done, in_ready, imem_we});
        end
        repeat (3) @(posedge tb_clk);
        #1;
        total++;
        if ({cpu_rst_n, done, in_ready} !== 3'b110) begin
            bad++;
            $display("FAIL inst_done_hold got rst_n/done/rdy=%b want 110",
                     {cpu_rst_n, done, in_ready});
        end
    endtask

    task automatic test_range_error();
        int i0, d0, nbad;
        reset_dut();
        i0 = n_imem_we;
        d0 = n_dmem_we;
        beat(32'h83FF_0002);
        total++;
        if ({err, in_ready, cpu_rst_n, done} !== 4'b1100) begin
            bad++;
            $display("FAIL range_enter got err/rdy/rst_n/done=%b want 1100",
                     {err, in_ready, cpu_rst_n, done});
        end
        nbad = 0;
        for (int i = 0; i < 20; i++) begin
            beat(32'h1000_0000 + 32'(i));
            if ({err, in_ready, cpu_rst_n, imem_we, dmem_we} !== 5'b11000) nbad++;
        end
        total++;
        if (nbad !== 0) begin
            bad++;
            $display("FAIL range_drain got %0d bad beats want 0", nbad);
        end
        @(negedge tb_clk);
        total++;
        if ((n_imem_we - i0) !== 0 || (n_dmem_we - d0) !== 0) begin
            bad++;
            $display("FAIL range_writes got i=%0d d=%0d want 0 0",
                     n_imem_we - i0, n_dmem_we - d0);
        end
    endtask

    task automatic test_reset_midload();
        reset_dut();
        beat(32'h0000_0003);
        beat(32'h1111_1111);
        total++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h1111_1111}) begin
            bad++;
            $display("FAIL mid_first got we=%b a=%0d d=%h want we=1 a=0 d=11111111",
                     imem_we, imem_addr, imem_wdata);
        end
        @(negedge tb_clk);
        rst = 1'b1;
        @(posedge tb_clk);
        #1;
        total++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, done, err} !== 47'd0) begin
            bad++;
            $display("FAIL mid_reset got rdy=%b we=%b a=%0d d=%h rst_n=%b done=%b err=%b want all 0",
                     in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, done, err);
        end
        @(negedge tb_clk);
        rst = 1'b0;
        beat(32'h0005_0001);
        beat(32'h2222_2222);
        total++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd5, 32'h2222_2222}) begin
            bad++;
            $display("FAIL mid_fresh got we=%b a=%0d d=%h want we=1 a=5 d=22222222",
                     imem_we, imem_addr, imem_wdata);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        repeat (2) @(posedge tb_clk);
        test_reset();
        test_data_load();
        test_stall();
        test_boundary();
        test_inst_load();
        test_range_error();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
